// File: rtl/fxp_divider.sv
// fxp_divider: sequential signed fixed-point divider, out = in1 / in2.
// Restoring shift-subtract division, one quotient bit per cycle, with
// truncation toward zero, saturation on overflow and divide-by-zero flag.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request; operands sampled when start=1 and not busy
//   in1    - signed dividend, Q(WI1.WF1)
//   in2    - signed divisor,  Q(WI2.WF2)
//   busy   - high from the cycle after an accepted start through done
//   done   - one-cycle pulse; out/OVF/DBZ valid from this cycle
//   out    - signed quotient, Q(WIO.WFO), held until the next done
//   OVF    - result saturated (includes divide-by-zero)
//   DBZ    - divisor was zero
module fxp_divider #(
    parameter int WI1 = 5,
    parameter int WF1 = 4,
    parameter int WI2 = 7,
    parameter int WF2 = 3,
    parameter int WIO = 8,
    parameter int WFO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WI1+WF1-1:0]     in1,
    input  logic [WI2+WF2-1:0]     in2,
    output logic                   busy,
    output logic                   done,
    output logic [WIO+WFO-1:0]     out,
    output logic                   OVF,
    output logic                   DBZ
);
    localparam int W1   = WI1 + WF1;
    localparam int W2   = WI2 + WF2;
    localparam int QW   = WIO + WFO;
    localparam int SH   = WFO + WF2 - WF1;   // aligns dividend so Q lands in output format
    localparam int NB   = W1 + SH;           // quotient bits iterated
    localparam int CNTW = $clog2(NB + 1);
    // Compare width wide enough for both the full quotient and the limits.
    localparam int CW   = ((NB > QW) ? NB : QW) + 1;

    localparam logic [CW-1:0] C_MAXP = (CW'(1) << (QW - 1)) - CW'(1);
    localparam logic [CW-1:0] C_MINM = CW'(1) << (QW - 1);
    localparam logic [QW-1:0] O_MAX  = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] O_MIN  = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic            r_sgn;
    logic            r_neg1;
    logic            r_dbz;
    logic [NB-1:0]   r_n;
    logic [W2-1:0]   r_d;
    logic [W2:0]     r_r;
    logic [NB-1:0]   r_q;
    logic [CNTW-1:0] r_cnt;

    logic [W1-1:0]   w_a;
    logic [W2-1:0]   w_d;
    logic [W2:0]     w_rsh;
    logic            w_ge;
    logic [CW-1:0]   w_qx;

    // Magnitudes as unsigned: the most negative value maps to 2^(W-1), which
    // still fits because the result is read unsigned.
    assign w_a   = in1[W1-1] ? -in1 : in1;
    assign w_d   = in2[W2-1] ? -in2 : in2;
    // Remainder stays below D after every step, so its low W2 bits suffice.
    assign w_rsh = {r_r[W2-1:0], r_n[NB-1]};
    assign w_ge  = (w_rsh >= {1'b0, r_d});
    assign w_qx  = CW'(r_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sgn   <= 1'b0;
            r_neg1  <= 1'b0;
            r_dbz   <= 1'b0;
            r_n     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= '0;
            OVF     <= 1'b0;
            DBZ     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sgn   <= in1[W1-1] ^ in2[W2-1];
                        r_neg1  <= in1[W1-1];
                        r_dbz   <= (in2 == '0);
                        r_n     <= NB'(w_a) << SH;
                        r_d     <= w_d;
                        r_r     <= '0;
                        r_q     <= '0;
                        r_cnt   <= CNTW'(NB);
                        busy    <= 1'b1;
                        r_state <= (in2 == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_n <= r_n << 1;
                    if (w_ge) begin
                        r_r <= w_rsh - {1'b0, r_d};
                        r_q <= {r_q[NB-2:0], 1'b1};
                    end else begin
                        r_r <= w_rsh;
                        r_q <= {r_q[NB-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CNTW'(1);
                    if (r_cnt == CNTW'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dbz) begin
                        out <= r_neg1 ? O_MIN : O_MAX;
                        OVF <= 1'b1;
                        DBZ <= 1'b1;
                    end else if (!r_sgn && (w_qx > C_MAXP)) begin
                        out <= O_MAX;
                        OVF <= 1'b1;
                        DBZ <= 1'b0;
                    end else if (r_sgn && (w_qx > C_MINM)) begin
                        out <= O_MIN;
                        OVF <= 1'b1;
                        DBZ <= 1'b0;
                    end else begin
                        // Negating zero gives zero, so -0 needs no special case.
                        out <= r_sgn ? -w_qx[QW-1:0] : w_qx[QW-1:0];
                        OVF <= 1'b0;
                        DBZ <= 1'b0;
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_divider.sv
// Scoreboard bench for fxp_divider with default Q formats
// (in1 Q5.4, in2 Q7.3, out Q8.4, NB = 12).
module tb_fxp_divider;
    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  in1;
    logic [9:0]  in2;
    logic        busy;
    logic        done;
    logic [11:0] out;
    logic        OVF;
    logic        DBZ;

    fxp_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .OVF   (OVF),
        .DBZ   (DBZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] o;
        logic        ovf;
        logic        dbz;
        int          lat;
        int          c0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 with no outstanding request (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out", int'(out), int'(e.o));
                chk("OVF", int'(OVF), int'(e.ovf));
                chk("DBZ", int'(DBZ), int'(e.dbz));
                chk("latency", cyc - e.c0, e.lat);
            end
        end
    end

    // Called at a negedge in an idle cycle; returns one negedge later (T+1).
    task automatic issue(input logic [8:0] a, input logic [9:0] b,
                         input logic [11:0] eo, input logic eovf, input logic edbz);
        exp_t e;
        in1   = a;
        in2   = b;
        start = 1'b1;
        e.o   = eo;
        e.ovf = eovf;
        e.dbz = edbz;
        e.lat = (b == 10'h000) ? 2 : 14;
        e.c0  = cyc;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high, then moves to the idle cycle.
    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected a done pulse", nm);
        end
        @(negedge clk);
    endtask

    int d1;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out",  int'(out),  0);
        chk("rst_OVF",  int'(OVF),  0);
        chk("rst_DBZ",  int'(DBZ),  0);
        rst = 1'b0;
        @(negedge clk);

        // 3.5 / 1.25 = 2.8 -> 2.75; busy held across T+1..T+14.
        issue(9'h038, 10'h00A, 12'h02C, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            chk("busy_high", int'(busy), 1);
            @(negedge clk);
        end
        chk("busy_low", int'(busy), 0);

        issue(9'h1C8, 10'h00A, 12'hFD4, 1'b0, 1'b0);   // -3.5 / 1.25
        wait_done("mixed");
        issue(9'h100, 10'h3FF, 12'h7FF, 1'b1, 1'b0);   // -16 / -0.125 = 128, saturates
        wait_done("ovf_pos");
        issue(9'h0FF, 10'h001, 12'h7F8, 1'b0, 1'b0);   // largest non-saturating
        wait_done("max_pos");
        issue(9'h100, 10'h001, 12'h800, 1'b0, 1'b0);   // -128 exactly, no saturation
        wait_done("min_neg");
        issue(9'h0FF, 10'h3FF, 12'h808, 1'b0, 1'b0);   // 15.9375 / -0.125
        wait_done("neg_big");
        issue(9'h000, 10'h3FF, 12'h000, 1'b0, 1'b0);   // -0 -> 0
        wait_done("neg_zero");
        issue(9'h010, 10'h000, 12'h7FF, 1'b1, 1'b1);   // 1.0 / 0
        wait_done("dbz_pos");
        issue(9'h1F0, 10'h000, 12'h800, 1'b1, 1'b1);   // -1.0 / 0
        wait_done("dbz_neg");

        // start during CALC must be ignored, and late operand changes unseen.
        issue(9'h038, 10'h00A, 12'h02C, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in1   = 9'h100;
        in2   = 10'h001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");

        // Back-to-back: second start in the first idle cycle after done.
        issue(9'h0FF, 10'h001, 12'h7F8, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        d1 = cyc;
        @(negedge clk);
        issue(9'h1C8, 10'h00A, 12'hFD4, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        chk("b2b_spacing", cyc - d1, 15);
        @(negedge clk);

        // Reset mid-operation: no done, outputs cleared, then normal op.
        in1   = 9'h010;
        in2   = 10'h00A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_out",  int'(out),  0);
        chk("mid_rst_OVF",  int'(OVF),  0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(9'h038, 10'h00A, 12'h02C, 1'b0, 1'b0);
        wait_done("after_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
